// File: rtl/shadow_dump_sequencer_if.sv
// shadow_dump_sequencer_if
//   Bundles the trigger, chain-group and serial-dump signals of the shadow
//   dump sequencer.
//   Modports:
//     master - the sequencer. It takes in trig, chain_mask and the per-chain
//              ch_out/ch_out_vld/ch_out_done, and drives c_en, dump_en, dout,
//              dout_vld, dout_chain, busy, round_done and err_timeout.
//     slave  - the debug controller plus the chain groups (the opposite
//              directions).
//   Parameter NUM_CHAINS sets the per-chain vector widths; CW is the chain-id
//   width.
interface shadow_dump_sequencer_if #(
    parameter int NUM_CHAINS = 4
) ();
    localparam int CW = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;

    logic                  trig;
    logic [NUM_CHAINS-1:0] chain_mask;
    logic                  c_en;
    logic [NUM_CHAINS-1:0] dump_en;
    logic [NUM_CHAINS-1:0] ch_out;
    logic [NUM_CHAINS-1:0] ch_out_vld;
    logic [NUM_CHAINS-1:0] ch_out_done;
    logic                  dout;
    logic                  dout_vld;
    logic [CW-1:0]         dout_chain;
    logic                  busy;
    logic                  round_done;
    logic                  err_timeout;

    modport master (
        input  trig, chain_mask, ch_out, ch_out_vld, ch_out_done,
        output c_en, dump_en, dout, dout_vld, dout_chain, busy, round_done, err_timeout
    );

    modport slave (
        output trig, chain_mask, ch_out, ch_out_vld, ch_out_done,
        input  c_en, dump_en, dout, dout_vld, dout_chain, busy, round_done, err_timeout
    );
endinterface

// File: rtl/shadow_dump_sequencer.sv
// shadow_dump_sequencer
//   Runs capture-freeze-dump rounds over NUM_CHAINS shadow chain groups that
//   share one serial port. While idle, capture stays enabled. A trigger
//   freezes every chain. The selected chains are then granted one at a time,
//   lowest index first. The granted chain's serial bits are forwarded, tagged
//   with its id. Every output is registered.
//   Ports:
//     sh_clk, sh_rst_n - clock, asynchronous active-low reset
//     bus (master)     - trig/chain_mask in, c_en/dump_en out, per-chain
//                        ch_out/ch_out_vld/ch_out_done in, dout/dout_vld/
//                        dout_chain out, busy/round_done/err_timeout out
//   Optional feature: define SHADOW_DUMP_TIMEOUT_EN to build a per-chain
//   watchdog (parameter TIMEOUT). When it is left undefined, err_timeout is
//   tied to 0.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | capture enabled, waiting for trig
//   S_FREEZE | capture dropped, letting chains settle for FREEZE_CYC cycles
//   S_SELECT | pick lowest pending chain and grant it, or finish the round
//   S_DUMP   | forward granted chain's bits until it reports done
//   S_FINISH | pulse round_done, re-enable capture
module shadow_dump_sequencer #(
    parameter int NUM_CHAINS = 4,
    parameter int FREEZE_CYC = 2
`ifdef SHADOW_DUMP_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 1024
`endif
) (
    input  logic                   sh_clk,
    input  logic                   sh_rst_n,
    shadow_dump_sequencer_if.master bus
);
    localparam int CW = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FREEZE = 3'd1,
        S_SELECT = 3'd2,
        S_DUMP   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            frz_q, frz_d;
    logic [NUM_CHAINS-1:0] pending_q, pending_d;
    logic [CW-1:0]         sel_q, sel_d;
    logic [NUM_CHAINS-1:0] dump_en_q, dump_en_d;
    logic                  c_en_q, c_en_d;
    logic                  busy_q, busy_d;
    logic                  round_done_q, round_done_d;
    logic                  dout_q, dout_d;
    logic                  dout_vld_q, dout_vld_d;
    logic [CW-1:0]         dout_chain_q, dout_chain_d;
    logic [CW-1:0]         low_idx;

`ifdef SHADOW_DUMP_TIMEOUT_EN
    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Reloading to TIMEOUT-2 and firing on terminal count 0 makes err land
    // exactly TIMEOUT cycles after the last valid bit.
    localparam logic [WW-1:0] WD_RELOAD = WW'(TIMEOUT - 2);
    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
`endif

    // Lowest set bit of pending: scanning downward leaves the smallest index.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CHAINS - 1; i >= 0; i--) begin
            if (pending_q[i]) low_idx = CW'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        frz_d        = frz_q;
        pending_d    = pending_q;
        sel_d        = sel_q;
        dump_en_d    = dump_en_q;
        c_en_d       = c_en_q;
        busy_d       = busy_q;
        round_done_d = 1'b0;
        dout_d       = dout_q;
        dout_vld_d   = 1'b0;
        dout_chain_d = dout_chain_q;
`ifdef SHADOW_DUMP_TIMEOUT_EN
        wd_d         = wd_q;
        err_d        = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                c_en_d = 1'b1;
                busy_d = 1'b0;
                if (bus.trig) begin
                    pending_d = bus.chain_mask;
                    c_en_d    = 1'b0;
                    busy_d    = 1'b1;
                    frz_d     = 4'(FREEZE_CYC - 1);
                    state_d   = S_FREEZE;
                end
            end
            S_FREEZE: begin
                if (frz_q == 4'd0) state_d = S_SELECT;
                else               frz_d   = frz_q - 4'd1;
            end
            S_SELECT: begin
                sel_d = low_idx;
                if (pending_q == '0) begin
                    state_d = S_FINISH;
                end else begin
                    dump_en_d = NUM_CHAINS'(1) << low_idx;
                    state_d   = S_DUMP;
`ifdef SHADOW_DUMP_TIMEOUT_EN
                    wd_d      = WD_RELOAD;
`endif
                end
            end
            S_DUMP: begin
                dout_d       = bus.ch_out[sel_q];
                dout_vld_d   = bus.ch_out_vld[sel_q];
                dout_chain_d = sel_q;
                if (bus.ch_out_done[sel_q]) begin
                    pending_d[sel_q] = 1'b0;
                    dump_en_d        = '0;
                    state_d          = S_SELECT;
                end
`ifdef SHADOW_DUMP_TIMEOUT_EN
                else if (bus.ch_out_vld[sel_q]) begin
                    wd_d = WD_RELOAD;
                end else if (wd_q == '0) begin
                    err_d            = 1'b1;
                    pending_d[sel_q] = 1'b0;
                    dump_en_d        = '0;
                    state_d          = S_SELECT;
                end else begin
                    wd_d = wd_q - 1'b1;
                end
`endif
            end
            S_FINISH: begin
                round_done_d = 1'b1;
                c_en_d       = 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sh_clk or negedge sh_rst_n) begin
        if (!sh_rst_n) begin
            state_q      <= S_IDLE;
            frz_q        <= '0;
            pending_q    <= '0;
            sel_q        <= '0;
            dump_en_q    <= '0;
            c_en_q       <= 1'b0;
            busy_q       <= 1'b0;
            round_done_q <= 1'b0;
            dout_q       <= 1'b0;
            dout_vld_q   <= 1'b0;
            dout_chain_q <= '0;
`ifdef SHADOW_DUMP_TIMEOUT_EN
            wd_q         <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            frz_q        <= frz_d;
            pending_q    <= pending_d;
            sel_q        <= sel_d;
            dump_en_q    <= dump_en_d;
            c_en_q       <= c_en_d;
            busy_q       <= busy_d;
            round_done_q <= round_done_d;
            dout_q       <= dout_d;
            dout_vld_q   <= dout_vld_d;
            dout_chain_q <= dout_chain_d;
`ifdef SHADOW_DUMP_TIMEOUT_EN
            wd_q         <= wd_d;
            err_q        <= err_d;
`endif
        end
    end

    assign bus.c_en       = c_en_q;
    assign bus.dump_en    = dump_en_q;
    assign bus.dout       = dout_q;
    assign bus.dout_vld   = dout_vld_q;
    assign bus.dout_chain = dout_chain_q;
    assign bus.busy       = busy_q;
    assign bus.round_done = round_done_q;
`ifdef SHADOW_DUMP_TIMEOUT_EN
    assign bus.err_timeout = err_q;
`else
    assign bus.err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_shadow_dump_sequencer.sv
// tb_shadow_dump_sequencer
//   Drives directed and randomized capture/dump rounds into
//   shadow_dump_sequencer. Each chain's bit list is generated up front. The
//   expected grant order and the expected tagged output stream are derived
//   from the chain mask: ascending index, every bit of a chain before the
//   next chain. Lanes that are not granted, trig and chain_mask are filled
//   with random noise, which the sequencer has to ignore.
//   Define SHADOW_DUMP_TIMEOUT_EN to add the watchdog scenario (TIMEOUT=16).
module tb_shadow_dump_sequencer;
    localparam int NC = 4;
    localparam int FC = 2;

    logic sh_clk   = 1'b0;
    logic sh_rst_n = 1'b0;
    always #5 sh_clk = ~sh_clk;

    shadow_dump_sequencer_if #(.NUM_CHAINS(NC)) sh ();

`ifdef SHADOW_DUMP_TIMEOUT_EN
    shadow_dump_sequencer #(.NUM_CHAINS(NC), .FREEZE_CYC(FC), .TIMEOUT(16)) dut (
        .sh_clk(sh_clk), .sh_rst_n(sh_rst_n), .bus(sh));
`else
    shadow_dump_sequencer #(.NUM_CHAINS(NC), .FREEZE_CYC(FC)) dut (
        .sh_clk(sh_clk), .sh_rst_n(sh_rst_n), .bus(sh));
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge sh_clk) cyc <= cyc + 1;

    // monitor state
    logic [NC-1:0] grants[$];
    int            stream[$];
    int            rd_cnt = 0;
    int            inv_bad = 0;
    int            err_rise_cyc = -1000;
    logic [NC-1:0] prev_de = '0;
    logic          prev_err = 1'b0;

    always @(negedge sh_clk) begin
        if (sh_rst_n) begin
            if (sh.dump_en != '0 && sh.dump_en != prev_de) grants.push_back(sh.dump_en);
            if (sh.dout_vld) stream.push_back(int'(sh.dout_chain) * 2 + int'(sh.dout));
            if (sh.round_done) rd_cnt++;
            if ($countones(sh.dump_en) > 1 || (sh.dump_en != '0 && sh.c_en)) inv_bad++;
            if (sh.err_timeout && !prev_err) err_rise_cyc = cyc;
        end
        prev_de  = sh.dump_en;
        prev_err = sh.err_timeout;
    end

    // reference data for the current round
    int            nb[NC];
    logic [7:0]    dat[NC];
    bit            same_last = 1'b0;
    int            hang = -1;
    logic [NC-1:0] exp_g[$];
    int            exp_s[$];
    int            exp_err = 0;
    int            trig_cyc, rd_cyc, hang_last_vld, busy_hi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        sh.trig        = 1'b0;
        sh.chain_mask  = '0;
        sh.ch_out      = '0;
        sh.ch_out_vld  = '0;
        sh.ch_out_done = '0;
    endtask

    function automatic int lowest(input logic [NC-1:0] v);
        lowest = -1;
        for (int i = NC - 1; i >= 0; i--) if (v[i]) lowest = i;
    endfunction

    task automatic build_expect(input logic [NC-1:0] m);
        logic [NC-1:0] one;
        exp_g.delete();
        exp_s.delete();
        for (int i = 0; i < NC; i++) begin
            if (m[i]) begin
                one = '0;
                one[i] = 1'b1;
                exp_g.push_back(one);
                for (int b = 0; b < nb[i]; b++) exp_s.push_back(i * 2 + int'(dat[i][b]));
            end
        end
    endtask

    task automatic start_round(input logic [NC-1:0] m);
        @(negedge sh_clk);
        idle();
        sh.chain_mask = m;
        sh.trig       = 1'b1;
        trig_cyc      = cyc;
        grants.delete();
        stream.delete();
        rd_cnt  = 0;
        inv_bad = 0;
        busy_hi = 0;
        build_expect(m);
    endtask

    // Plays the chain groups for one round. need_end=0 stops after max_cyc cycles.
    task automatic serve(input int max_cyc, input bit need_end);
        int  g, bp, ng, last_done;
        bit  ended, first;
        g = -1; bp = 0; ended = 1'b0; first = 1'b1; last_done = -100;
        for (int c = 0; c < max_cyc && !ended; c++) begin
            @(negedge sh_clk);
            if (c == 0) begin
                chk("c_en_drop", sh.c_en, 0);
                chk("busy_rise", sh.busy, 1);
            end
            if (sh.round_done) begin
                ended  = 1'b1;
                rd_cyc = cyc;
                idle();
            end else begin
                if (sh.busy) busy_hi++;
                sh.trig        = 1'($urandom_range(1));
                sh.chain_mask  = NC'($urandom);
                sh.ch_out      = NC'($urandom);
                sh.ch_out_vld  = NC'($urandom);
                sh.ch_out_done = NC'($urandom);
                if (sh.dump_en != '0) begin
                    ng = lowest(sh.dump_en);
                    if (ng != g) begin
                        if (first) chk("first_grant_lat", cyc - trig_cyc, 2 + FC);
                        if (last_done >= 0) chk("grant_gap", cyc - last_done, 2);
                        first = 1'b0; last_done = -100; g = ng; bp = 0;
                    end
                    sh.ch_out_vld[g]  = 1'b0;
                    sh.ch_out_done[g] = 1'b0;
                    if (bp < nb[g]) begin
                        if ($urandom_range(3) != 0) begin
                            sh.ch_out_vld[g] = 1'b1;
                            sh.ch_out[g]     = dat[g][bp];
                            bp++;
                            if (g == hang) hang_last_vld = cyc;
                            if (bp == nb[g] && same_last && g != hang) begin
                                sh.ch_out_done[g] = 1'b1;
                                last_done = cyc;
                            end
                        end
                    end else if (g != hang) begin
                        sh.ch_out_done[g] = 1'b1;
                        last_done = cyc;
                    end
                end else begin
                    g = -1;
                end
            end
        end
        if (need_end) begin
            chk("round_end", ended, 1);
            if (ended) begin
                chk("busy_window", busy_hi, rd_cyc - trig_cyc - 1);
                chk("busy_fall", sh.busy, 0);
                chk("c_en_back", sh.c_en, 1);
            end
        end
    endtask

    task automatic check_round();
        repeat (3) @(negedge sh_clk);
        #1;
        chk("round_done_cnt", rd_cnt, 1);
        chk("idle_c_en", sh.c_en, 1);
        chk("idle_busy", sh.busy, 0);
        chk("grant_cnt", grants.size(), exp_g.size());
        for (int i = 0; i < grants.size() && i < exp_g.size(); i++) chk("grant", grants[i], exp_g[i]);
        chk("stream_len", stream.size(), exp_s.size());
        for (int i = 0; i < stream.size() && i < exp_s.size(); i++) chk("stream_bit", stream[i], exp_s[i]);
        chk("invariant", inv_bad, 0);
        chk("err_timeout", sh.err_timeout, exp_err);
    endtask

    task automatic rand_data(input int max_bits);
        for (int i = 0; i < NC; i++) begin
            nb[i]  = $urandom_range(max_bits);
            dat[i] = 8'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $fatal(1, "stopped");
    end

    initial begin
        idle();
        repeat (2) @(negedge sh_clk);
        #1;
        chk("rst_c_en", sh.c_en, 0);
        chk("rst_busy", sh.busy, 0);
        chk("rst_dump_en", sh.dump_en, 0);
        chk("rst_dout_vld", sh.dout_vld, 0);
        chk("rst_round_done", sh.round_done, 0);
        @(negedge sh_clk);
        sh_rst_n = 1'b1;
        #1 chk("c_en_pre_edge", sh.c_en, 0);
        @(negedge sh_clk);
        #1 chk("c_en_after_rst", sh.c_en, 1);

        // three chains, three bits each, done in its own cycle
        for (int i = 0; i < NC; i++) begin nb[i] = 3; dat[i] = 8'($urandom); end
        same_last = 1'b0;
        start_round(4'b1011);
        serve(300, 1'b1);
        check_round();

        // empty mask
        start_round(4'b0000);
        serve(50, 1'b1);
        chk("empty_rd_lat", rd_cyc - trig_cyc, 3 + FC);
        check_round();

        // last bit of chain 1 carries done
        rand_data(4);
        nb[1] = 3; nb[2] = 2;
        same_last = 1'b1;
        start_round(4'b0110);
        serve(300, 1'b1);
        check_round();

        // randomized rounds
        for (int r = 0; r < 10; r++) begin
            rand_data(4);
            same_last = 1'($urandom_range(1));
            start_round(NC'($urandom));
            serve(400, 1'b1);
            check_round();
        end

        // reset in the middle of a dump
        for (int i = 0; i < NC; i++) begin nb[i] = 5; dat[i] = 8'($urandom); end
        same_last = 1'b0;
        start_round(4'b1111);
        serve(8, 1'b0);
        idle();
        #2 chk("mid_dump", sh.dump_en != '0, 1);
        sh_rst_n = 1'b0;
        #1;
        chk("arst_c_en", sh.c_en, 0);
        chk("arst_dump_en", sh.dump_en, 0);
        chk("arst_busy", sh.busy, 0);
        chk("arst_dout", sh.dout, 0);
        chk("arst_dout_vld", sh.dout_vld, 0);
        chk("arst_dout_chain", sh.dout_chain, 0);
        chk("arst_round_done", sh.round_done, 0);
        chk("arst_err", sh.err_timeout, 0);
        @(negedge sh_clk);
        sh_rst_n = 1'b1;
        #1 chk("rel_c_en_0", sh.c_en, 0);
        @(negedge sh_clk);
        #1 chk("rel_c_en_1", sh.c_en, 1);
        chk("rel_busy", sh.busy, 0);
        rand_data(3);
        start_round(4'b1111);
        serve(400, 1'b1);
        check_round();

`ifdef SHADOW_DUMP_TIMEOUT_EN
        // chain 1 never reports done
        rand_data(3);
        nb[1] = 3; nb[2] = 2;
        hang = 1;
        same_last = 1'b0;
        start_round(4'b0110);
        serve(400, 1'b1);
        exp_err = 1;
        check_round();
        chk("timeout_lat", err_rise_cyc - hang_last_vld, 16);
        hang = -1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
